// File: rtl/serial_operand_shifter_if.sv
// Operand/serial bus for serial_operand_shifter.
// The master side offers parallel operand pairs and watches the serial bit stream.
// The slave side is the shifter itself.
interface serial_operand_shifter_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             a;
  logic             b;
  logic             bit_valid;
  logic             last;
  logic             clr;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b,
    input  in_ready, a, b, bit_valid, last, clr, busy
  );

  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready, a, b, bit_valid, last, clr, busy
  );
endinterface

// File: rtl/serial_operand_shifter.sv
// serial_operand_shifter: feeds a Moore serial adder from parallel operand pairs.
// Each accepted pair produces one clr cycle followed by WIDTH bit pairs, LSB first.
// Optional feature macro: OPSER_PREFETCH_EN adds a one-entry hold register so the
// next pair can be taken while a word is shifting, removing the idle cycle between words.
module serial_operand_shifter #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  serial_operand_shifter_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] opa_reg, opa_next;
  logic [WIDTH-1:0] opb_reg, opb_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             a_reg, a_next;
  logic             b_reg, b_next;
  logic             bit_valid_reg, bit_valid_next;
  logic             last_reg, last_next;
  logic             clr_reg, clr_next;
  logic             in_ready;
  logic             accept;
  logic             word_done;

`ifdef OPSER_PREFETCH_EN
  logic [WIDTH-1:0] hold_a_reg, hold_a_next;
  logic [WIDTH-1:0] hold_b_reg, hold_b_next;
  logic             hold_full_reg, hold_full_next;

  // With a hold slot the only reason to refuse a pair is that the slot is occupied.
  assign in_ready = !hold_full_reg;
`else
  assign in_ready = (state_reg == IDLE);
`endif

  assign accept    = bus.in_valid && in_ready;
  // A new word may start from IDLE or straight after the final bit of the current one.
  assign word_done = (state_reg == IDLE) || ((state_reg == SHIFT) && (cnt_reg == LAST_IDX));

  // Next-state logic; serial outputs are computed one cycle ahead so they leave registered.
  always_comb begin
    state_next     = state_reg;
    opa_next       = opa_reg;
    opb_next       = opb_reg;
    cnt_next       = cnt_reg;
    a_next         = 1'b0;
    b_next         = 1'b0;
    bit_valid_next = 1'b0;
    last_next      = 1'b0;
    clr_next       = 1'b0;
`ifdef OPSER_PREFETCH_EN
    hold_a_next    = hold_a_reg;
    hold_b_next    = hold_b_reg;
    hold_full_next = hold_full_reg;
`endif

    if (state_reg == CLEAR) begin
      // Leaving CLEAR: present bit 0 and start the count.
      state_next     = SHIFT;
      cnt_next       = '0;
      a_next         = opa_reg[0];
      b_next         = opb_reg[0];
      opa_next       = opa_reg >> 1;
      opb_next       = opb_reg >> 1;
      bit_valid_next = 1'b1;
    end else if ((state_reg == SHIFT) && (cnt_reg != LAST_IDX)) begin
      cnt_next       = cnt_reg + CW'(1);
      a_next         = opa_reg[0];
      b_next         = opb_reg[0];
      opa_next       = opa_reg >> 1;
      opb_next       = opb_reg >> 1;
      bit_valid_next = 1'b1;
      last_next      = ((cnt_reg + CW'(1)) == LAST_IDX);
    end

`ifdef OPSER_PREFETCH_EN
    if (word_done && hold_full_reg) begin
      // Queued pair goes straight into the shifter; IDLE is skipped.
      state_next     = CLEAR;
      clr_next       = 1'b1;
      cnt_next       = '0;
      opa_next       = hold_a_reg;
      opb_next       = hold_b_reg;
      hold_full_next = accept;
      if (accept) begin
        hold_a_next = bus.in_a;
        hold_b_next = bus.in_b;
      end
    end else if (word_done && accept) begin
      state_next = CLEAR;
      clr_next   = 1'b1;
      cnt_next   = '0;
      opa_next   = bus.in_a;
      opb_next   = bus.in_b;
    end else if (accept) begin
      // Busy mid-word: park the pair until the current word finishes.
      hold_a_next    = bus.in_a;
      hold_b_next    = bus.in_b;
      hold_full_next = 1'b1;
    end else if (word_done) begin
      state_next = IDLE;
      cnt_next   = '0;
    end
`else
    if (word_done && accept) begin
      state_next = CLEAR;
      clr_next   = 1'b1;
      cnt_next   = '0;
      opa_next   = bus.in_a;
      opb_next   = bus.in_b;
    end else if (word_done) begin
      state_next = IDLE;
      cnt_next   = '0;
    end
`endif
  end

  // State, operand and output registers; reset aborts any word without a clr pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      opa_reg       <= '0;
      opb_reg       <= '0;
      cnt_reg       <= '0;
      a_reg         <= 1'b0;
      b_reg         <= 1'b0;
      bit_valid_reg <= 1'b0;
      last_reg      <= 1'b0;
      clr_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      opa_reg       <= opa_next;
      opb_reg       <= opb_next;
      cnt_reg       <= cnt_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      bit_valid_reg <= bit_valid_next;
      last_reg      <= last_next;
      clr_reg       <= clr_next;
    end
  end

`ifdef OPSER_PREFETCH_EN
  // Hold slot for the prefetched operand pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_a_reg    <= '0;
      hold_b_reg    <= '0;
      hold_full_reg <= 1'b0;
    end else begin
      hold_a_reg    <= hold_a_next;
      hold_b_reg    <= hold_b_next;
      hold_full_reg <= hold_full_next;
    end
  end
`endif

  assign bus.in_ready  = in_ready;
  assign bus.a         = a_reg;
  assign bus.b         = b_reg;
  assign bus.bit_valid = bit_valid_reg;
  assign bus.last      = last_reg;
  assign bus.clr       = clr_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_serial_operand_shifter.sv
// Bench for serial_operand_shifter (WIDTH=8) with a serial adder model downstream.
// The driver pushes hand-computed words into a scoreboard queue on each accept; a
// negedge monitor rebuilds A/B from the bit stream, runs them through the adder model
// (carry cleared by clr) and compares against the queue head on the last bit.
module tb_serial_operand_shifter;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       carry;
  } exp_t;

`ifdef OPSER_PREFETCH_EN
  localparam int PERIOD = 9;
`else
  localparam int PERIOD = 10;
`endif

  logic clk;
  logic reset;
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   acc_cnt;
  exp_t exp_q[$];
  int   clr_times[$];
  int   acc_times[$];

  serial_operand_shifter_if #(.WIDTH(8)) bus_if ();

  serial_operand_shifter #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && bus_if.in_valid && bus_if.in_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: downstream adder model plus framing checks.
  logic [7:0] mon_a, mon_b, mon_sum;
  logic       mon_carry, mon_clr_seen, prev_clr;
  int         nbits;

  always @(negedge clk) begin
    if (reset) begin
      nbits        = 0;
      mon_carry    = 1'b0;
      mon_clr_seen = 1'b0;
      prev_clr     = 1'b0;
    end else begin
      if (bus_if.clr) begin
        check("clr_one_cycle", prev_clr, 1'b0);
        check("clr_between_words", nbits, 0);
        check("clr_no_bit", bus_if.bit_valid, 1'b0);
        mon_carry    = 1'b0;
        mon_clr_seen = 1'b1;
        clr_times.push_back(cyc);
      end
      prev_clr = bus_if.clr;
      if (bus_if.bit_valid) begin
        mon_a[nbits]   = bus_if.a;
        mon_b[nbits]   = bus_if.b;
        mon_sum[nbits] = bus_if.a ^ bus_if.b ^ mon_carry;
        mon_carry      = (bus_if.a & bus_if.b) | (mon_carry & (bus_if.a ^ bus_if.b));
        check("last_position", bus_if.last, (nbits == 7));
        nbits++;
        if (bus_if.last || nbits == 8) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", 1'b1, 1'b0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("[TB] word a=%02h b=%02h -> sum=%02h carry=%0b (expect a=%02h b=%02h sum=%02h carry=%0b)",
                     mon_a, mon_b, mon_sum, mon_carry, e.a, e.b, e.sum, e.carry);
            check("serial_a", mon_a, e.a);
            check("serial_b", mon_b, e.b);
            check("adder_sum", mon_sum, e.sum);
            check("adder_carry", mon_carry, e.carry);
            check("clr_before_word", mon_clr_seen, 1'b1);
          end
          mon_clr_seen = 1'b0;
          nbits        = 0;
        end
      end else begin
        if (nbits != 0) check("bit_gap", 1'b1, 1'b0);
        nbits = 0;
        if (bus_if.a || bus_if.b || bus_if.last) check("idle_outputs_zero", {bus_if.a, bus_if.b, bus_if.last}, 3'b000);
      end
    end
  end

  // Offer one pair; on accept record the expected adder result when push is set.
  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] es,
                      input logic ec, input bit push);
    int   n;
    exp_t e;
    n = 0;
    bus_if.in_a     = av;
    bus_if.in_b     = bv;
    bus_if.in_valid = 1'b1;
    @(negedge clk);
    while (!bus_if.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus_if.in_ready) begin
      check("accept_timeout", 1'b0, 1'b1);
    end else begin
      @(posedge clk);
      acc_times.push_back(cyc);
      if (push) begin
        e.a = av; e.b = bv; e.sum = es; e.carry = ec;
        exp_q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(posedge clk);
    while ((exp_q.size() != 0 || bus_if.busy) && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain_done", (exp_q.size() == 0) && !bus_if.busy, 1'b1);
    #1;
  endtask

  initial begin
    int base_acc;
    int nc;
    n_tests = 0;
    n_fail  = 0;
    acc_cnt = 0;
    cyc     = 0;
    reset   = 1'b1;
    bus_if.in_valid = 1'b0;
    bus_if.in_a     = '0;
    bus_if.in_b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus_if.a, bus_if.b, bus_if.bit_valid, bus_if.last, bus_if.clr, bus_if.busy}, 6'b0);
    check("reset_in_ready", bus_if.in_ready, 1'b1);
    reset = 1'b0;

    // Basic word.
    send(8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1);
    bus_if.in_valid = 1'b0;
    wait_idle();

    // Carry-out word followed back-to-back by zeros: carry must not leak.
    send(8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
    send(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    bus_if.in_valid = 1'b0;
    wait_idle();
    nc = clr_times.size();
    check("clr_spacing_b2b", clr_times[nc-1] - clr_times[nc-2], PERIOD);

`ifndef OPSER_PREFETCH_EN
    // in_valid held through the whole busy period: exactly one accept.
    base_acc = acc_cnt;
    send(8'h12, 8'h34, 8'h46, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("in_ready_low_busy", bus_if.in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    check("single_accept", acc_cnt - base_acc, 1);
    wait_idle();
`endif

    // Reset in the middle of a word at bit 3.
    send(8'hAA, 8'h55, 8'h00, 1'b0, 1'b0);
    bus_if.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_bit3_live", {bus_if.bit_valid, bus_if.a, bus_if.b}, 3'b110);
    reset = 1'b1;
    #1;
    check("abort_async_clear", {bus_if.a, bus_if.b, bus_if.bit_valid, bus_if.last, bus_if.clr, bus_if.busy}, 6'b0);
    @(posedge clk);
    #1;
    check("abort_outputs", {bus_if.a, bus_if.b, bus_if.bit_valid, bus_if.last, bus_if.clr, bus_if.busy}, 6'b0);
    check("abort_in_ready", bus_if.in_ready, 1'b1);
    reset = 1'b0;
    send(8'h01, 8'h01, 8'h02, 1'b0, 1'b1);
    bus_if.in_valid = 1'b0;
    wait_idle();

    // MSB-only operands: last bit carries a=b=1.
    send(8'h80, 8'h80, 8'h00, 1'b1, 1'b1);
    bus_if.in_valid = 1'b0;
    wait_idle();

`ifdef OPSER_PREFETCH_EN
    // Three pairs offered back-to-back: second is prefetched, third waits for the drain.
    send(8'h11, 8'h22, 8'h33, 1'b0, 1'b1);
    send(8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b1);
    send(8'hC3, 8'h81, 8'h44, 1'b1, 1'b1);
    bus_if.in_valid = 1'b0;
    wait_idle();
    nc = acc_times.size();
    check("prefetch_accept_during_word", acc_times[nc-2] - acc_times[nc-3], 1);
    check("prefetch_third_after_drain", acc_times[nc-1] - acc_times[nc-2], 9);
    nc = clr_times.size();
    check("prefetch_clr_spacing_1", clr_times[nc-2] - clr_times[nc-3], 9);
    check("prefetch_clr_spacing_2", clr_times[nc-1] - clr_times[nc-2], 9);
    base_acc = 0;
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
